// File: rtl/monitor_pkg.sv
// Shared definitions for the vital-sign monitors: alarm state encoding,
// default debounce/clear/blink settings and the normal temperature window.
package monitor_pkg;

    typedef enum logic [2:0] {
        ST_NORMAL  = 3'd0,
        ST_SUSPECT = 3'd1,
        ST_ALARM   = 3'd2,
        ST_ACKED   = 3'd3,
        ST_RECOVER = 3'd4
    } alarm_state_e;

    localparam int CONFIRM_COUNT_DEFAULT = 3;
    localparam int CLEAR_COUNT_DEFAULT   = 4;
    localparam int BLINK_HALF_DEFAULT    = 25000000;

    localparam logic [7:0] TEMP_LOW_C  = 8'd35;
    localparam logic [7:0] TEMP_HIGH_C = 8'd39;

    localparam logic [7:0] EVENT_COUNT_MAX = 8'hFF;

endpackage

// File: rtl/alarm_blinker.sv
// Registered square-wave generator with a BLINK_HALF-cycle half-period.
// restart forces the output high with a fresh period; dropping enable parks it low.
module alarm_blinker
    import monitor_pkg::*;
#(
    parameter int BLINK_HALF = BLINK_HALF_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic restart,
    output logic wave
);

    localparam int CW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [CW-1:0] LAST = CW'(BLINK_HALF - 1);

    logic [CW-1:0] cnt_d, cnt_q;
    logic          wave_d, wave_q;

    // Next half-period counter and wave level.
    always_comb begin
        cnt_d  = cnt_q;
        wave_d = wave_q;
        if (restart) begin
            cnt_d  = {CW{1'b0}};
            wave_d = 1'b1;
        end else if (enable) begin
            if (cnt_q == LAST) begin
                cnt_d  = {CW{1'b0}};
                wave_d = ~wave_q;
            end else begin
                cnt_d  = cnt_q + CW'(1);
            end
        end else begin
            cnt_d  = {CW{1'b0}};
            wave_d = 1'b0;
        end
    end

    // Blinker state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= {CW{1'b0}};
            wave_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wave_q <= wave_d;
        end
    end

    assign wave = wave_q;

endmodule

// File: rtl/temperature_alarm_controller.sv
// Debounces the per-sample temperature abnormality flag into a latched ward
// alarm that needs a nurse acknowledge plus sustained normal readings to clear.
module temperature_alarm_controller
    import monitor_pkg::*;
#(
    parameter int CONFIRM_COUNT = CONFIRM_COUNT_DEFAULT,
    parameter int CLEAR_COUNT   = CLEAR_COUNT_DEFAULT,
    parameter int BLINK_HALF    = BLINK_HALF_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sampleValid,
    input  logic       temperatureAbnormality,
    input  logic       alarmAck,
    output logic       alarm,
    output logic       buzzer,
    output logic [2:0] alarmState,
    output logic [7:0] abnormalEventCount
);

    alarm_state_e state_d, state_q;
    logic [3:0]   cnt_d, cnt_q;
    logic [7:0]   event_cnt_d, event_cnt_q;
    logic         alarm_d, alarm_q;
    logic         blink_enable_s, blink_restart_s;
    logic         blink_wave_s;

    // State and sample-counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_NORMAL;
            cnt_q       <= 4'd0;
            event_cnt_q <= 8'd0;
            alarm_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            event_cnt_q <= event_cnt_d;
            alarm_q     <= alarm_d;
        end
    end

    // Next state: only valid samples advance the FSM, except the ALARM acknowledge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_NORMAL: begin
                if (sampleValid) begin
                    if (temperatureAbnormality) begin
                        state_d = ST_SUSPECT;
                        cnt_d   = 4'd1;
                    end else begin
                        cnt_d   = 4'd0;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_SUSPECT: begin
                if (sampleValid) begin
                    if (!temperatureAbnormality) begin
                        state_d = ST_NORMAL;
                        cnt_d   = 4'd0;
                    end else if (cnt_q + 4'd1 == 4'(CONFIRM_COUNT)) begin
                        state_d = ST_ALARM;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_ALARM: begin
                if (alarmAck) begin
                    state_d = ST_ACKED;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_ACKED: begin
                if (sampleValid) begin
                    if (temperatureAbnormality) begin
                        cnt_d   = 4'd0;
                    end else if (CLEAR_COUNT == 1) begin
                        state_d = ST_NORMAL;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_RECOVER;
                        cnt_d   = 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_RECOVER: begin
                if (sampleValid) begin
                    if (temperatureAbnormality) begin
                        state_d = ST_ACKED;
                        cnt_d   = 4'd0;
                    end else if (cnt_q + 4'd1 == 4'(CLEAR_COUNT)) begin
                        state_d = ST_NORMAL;
                        cnt_d   = 4'd0;
                    end else begin
                        cnt_d   = cnt_q + 4'd1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_NORMAL;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Outputs derived from the transition so they appear the cycle after the sample.
    always_comb begin
        alarm_d         = (state_d == ST_ALARM) || (state_d == ST_ACKED) ||
                          (state_d == ST_RECOVER);
        blink_restart_s = (state_q != ST_ALARM) && (state_d == ST_ALARM);
        blink_enable_s  = (state_q == ST_ALARM) && (state_d == ST_ALARM);
        if ((state_q == ST_SUSPECT) && (state_d == ST_ALARM) &&
            (event_cnt_q != EVENT_COUNT_MAX)) begin
            event_cnt_d = event_cnt_q + 8'd1;
        end else begin
            event_cnt_d = event_cnt_q;
        end
    end

    alarm_blinker #(
        .BLINK_HALF(BLINK_HALF)
    ) u_blinker (
        .clk    (clk),
        .rst    (rst),
        .enable (blink_enable_s),
        .restart(blink_restart_s),
        .wave   (blink_wave_s)
    );

    assign alarm              = alarm_q;
    assign buzzer             = blink_wave_s;
    assign alarmState         = state_q;
    assign abnormalEventCount = event_cnt_q;

endmodule

// File: tb/tb_temperature_alarm_controller.sv
// Directed, table-driven bench for temperature_alarm_controller with
// CONFIRM_COUNT=3, CLEAR_COUNT=4, BLINK_HALF=4.
module tb_temperature_alarm_controller;

    localparam int CC = 3;
    localparam int CLC = 4;
    localparam int BH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       sv, ab, ack;
    logic       alarm, buzzer;
    logic [2:0] alarm_state;
    logic [7:0] event_count;

    int n_checks = 0;
    int n_fail   = 0;

    temperature_alarm_controller #(
        .CONFIRM_COUNT(CC),
        .CLEAR_COUNT  (CLC),
        .BLINK_HALF   (BH)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .sampleValid           (sv),
        .temperatureAbnormality(ab),
        .alarmAck              (ack),
        .alarm                 (alarm),
        .buzzer                (buzzer),
        .alarmState            (alarm_state),
        .abnormalEventCount    (event_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       sv;
        logic       ab;
        logic       ack;
        logic       al;
        logic       bz;
        logic [2:0] st;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic s, input logic a, input logic k,
                                input logic al, input logic bz,
                                input logic [2:0] st, input logic [7:0] cnt);
        vec_t v;
        v.sv = s; v.ab = a; v.ack = k;
        v.al = al; v.bz = bz; v.st = st; v.cnt = cnt;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input logic al, input logic bz,
                             input logic [2:0] st, input logic [7:0] cnt);
        check({tag, ".alarm"},  {7'd0, alarm},  {7'd0, al});
        check({tag, ".buzzer"}, {7'd0, buzzer}, {7'd0, bz});
        check({tag, ".state"},  {5'd0, alarm_state}, {5'd0, st});
        check({tag, ".events"}, event_count, cnt);
    endtask

    task automatic step(input logic s, input logic a, input logic k);
        sv = s; ab = a; ack = k;
        @(posedge clk);
        #1;
        sv = 1'b0; ab = 1'b0; ack = 1'b0;
    endtask

    // One full alarm cycle: confirm, acknowledge, clear.
    task automatic alarm_cycle();
        for (int i = 0; i < CC; i++) step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < CLC; i++) step(1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1; sv = 1'b0; ab = 1'b0; ack = 1'b0;
        #12;
        check_all("reset", 1'b0, 1'b0, 3'd0, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // sv, ab, ack -> alarm, buzzer, state, events (after the edge)
        vecs.push_back(mk(1,1,0, 0,0,1,0));
        vecs.push_back(mk(0,0,1, 0,0,1,0));
        vecs.push_back(mk(1,1,0, 0,0,1,0));
        vecs.push_back(mk(1,0,0, 0,0,0,0));
        vecs.push_back(mk(0,0,1, 0,0,0,0));
        vecs.push_back(mk(1,1,0, 0,0,1,0));
        vecs.push_back(mk(1,1,1, 0,0,1,0));
        vecs.push_back(mk(0,0,0, 0,0,1,0));
        vecs.push_back(mk(1,1,0, 1,1,2,1));
        vecs.push_back(mk(0,0,0, 1,1,2,1));
        vecs.push_back(mk(0,0,0, 1,1,2,1));
        vecs.push_back(mk(0,0,0, 1,1,2,1));
        vecs.push_back(mk(0,0,0, 1,0,2,1));
        vecs.push_back(mk(0,0,0, 1,0,2,1));
        vecs.push_back(mk(0,0,0, 1,0,2,1));
        vecs.push_back(mk(1,1,0, 1,0,2,1));
        vecs.push_back(mk(0,0,0, 1,1,2,1));
        vecs.push_back(mk(1,0,0, 1,1,2,1));
        vecs.push_back(mk(0,0,1, 1,0,3,1));
        vecs.push_back(mk(1,0,0, 1,0,4,1));
        vecs.push_back(mk(1,0,0, 1,0,4,1));
        vecs.push_back(mk(1,0,0, 1,0,4,1));
        vecs.push_back(mk(1,1,0, 1,0,3,1));
        vecs.push_back(mk(1,1,0, 1,0,3,1));
        vecs.push_back(mk(1,0,0, 1,0,4,1));
        vecs.push_back(mk(0,0,0, 1,0,4,1));
        vecs.push_back(mk(1,0,0, 1,0,4,1));
        vecs.push_back(mk(1,0,0, 1,0,4,1));
        vecs.push_back(mk(1,0,0, 0,0,0,1));
        vecs.push_back(mk(0,0,1, 0,0,0,1));
        vecs.push_back(mk(1,1,0, 0,0,1,1));
        vecs.push_back(mk(1,1,0, 0,0,1,1));
        vecs.push_back(mk(1,1,0, 1,1,2,2));
        vecs.push_back(mk(1,0,1, 1,0,3,2));
        vecs.push_back(mk(1,0,0, 1,0,4,2));
        vecs.push_back(mk(1,0,0, 1,0,4,2));
        vecs.push_back(mk(1,0,0, 1,0,4,2));
        vecs.push_back(mk(1,0,0, 0,0,0,2));

        foreach (vecs[i]) begin
            step(vecs[i].sv, vecs[i].ab, vecs[i].ack);
            check_all($sformatf("vec%0d", i), vecs[i].al, vecs[i].bz, vecs[i].st, vecs[i].cnt);
        end

        // Raise with 5-cycle idle gaps between abnormal samples.
        for (int s = 0; s < CC; s++) begin
            step(1'b1, 1'b1, 1'b0);
            if (s < CC - 1) begin
                check($sformatf("gap_raise.alarm_s%0d", s), {7'd0, alarm}, 8'd0);
                for (int g = 0; g < 5; g++) step(1'b0, 1'b0, 1'b0);
                check($sformatf("gap_raise.idle_s%0d", s), {7'd0, alarm}, 8'd0);
            end else begin
                check_all("gap_raise.final", 1'b1, 1'b1, 3'd2, 8'd3);
            end
        end
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < CLC; i++) step(1'b1, 1'b0, 1'b0);
        check_all("gap_raise.cleared", 1'b0, 1'b0, 3'd0, 8'd3);

        // Drive the event counter into saturation and beyond.
        for (int i = 4; i <= 255; i++) alarm_cycle();
        check_all("sat.reach", 1'b0, 1'b0, 3'd0, 8'd255);
        alarm_cycle();
        check_all("sat.hold", 1'b0, 1'b0, 3'd0, 8'd255);

        // Asynchronous reset while the alarm is sounding.
        for (int i = 0; i < CC; i++) step(1'b1, 1'b1, 1'b0);
        check_all("pre_rst", 1'b1, 1'b1, 3'd2, 8'd255);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 1'b0, 1'b0, 3'd0, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        check_all("post_rst", 1'b0, 1'b0, 3'd1, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
